// File: rtl/instr_seq_if.sv
// Bus between the instruction sequencer and the MSP430 datapath/memory.
// Handshake: during a bus state the sequencer holds MEM_req=1 together with a
// stable MAB_sel. Memory answers with mem_rdy=1 in the cycle the access
// completes. Completion strobes (PC_inc, *_ld, AUTOINC/INC2, MW, instr_done)
// are valid only in that cycle. The FSM advances on the posedge that samples
// mem_rdy=1 and otherwise holds the state.
interface instr_seq_if;
  logic [15:0] MDB_out;
  logic        mem_rdy;
  logic [15:0] IR_out;
  logic [3:0]  state;
  logic        MEM_req;
  logic [2:0]  MAB_sel;
  logic        PC_inc;
  logic        SRCX_ld;
  logic        DSTX_ld;
  logic        SOP_ld;
  logic        DOP_ld;
  logic        AUTOINC;
  logic        INC2;
  logic        RW;
  logic        MW;
  logic        JMP;
  logic        instr_done;
  logic        illegal;

  modport master (
    input  MDB_out, mem_rdy,
    output IR_out, state, MEM_req, MAB_sel, PC_inc, SRCX_ld, DSTX_ld,
           SOP_ld, DOP_ld, AUTOINC, INC2, RW, MW, JMP, instr_done, illegal
  );

  modport slave (
    output MDB_out, mem_rdy,
    input  IR_out, state, MEM_req, MAB_sel, PC_inc, SRCX_ld, DSTX_ld,
           SOP_ld, DOP_ld, AUTOINC, INC2, RW, MW, JMP, instr_done, illegal
  );
endinterface

// File: rtl/instr_seq.sv
// Multi-cycle MSP430 instruction sequencer: owns the IR and steps each
// instruction through fetch, extension words, operand reads, execute and
// memory write-back, driving MAB select and datapath strobes.
module instr_seq (
  input  logic        clk,
  input  logic        rst,
  instr_seq_if.master bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    SRC_EXT = 4'd3,
    SRC_RD  = 4'd4,
    DST_EXT = 4'd5,
    DST_RD  = 4'd6,
    EXEC    = 4'd7,
    DST_WR  = 4'd8
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;

  // Instruction decode, all taken straight from the IR (stable after FETCH).
  logic       w_jmp_fmt, w_f2, w_f1, w_legal;
  logic [3:0] w_src;
  logic [1:0] w_as;
  logic       w_ad, w_cg, w_writes, w_is_mov, w_mem_dst, w_inc2;
  state_t     w_dst_entry;

  assign w_jmp_fmt   = (r_ir[15:13] == 3'b001);
  assign w_f2        = (r_ir[15:10] == 6'b000100) && (r_ir[9:7] <= 3'd3);
  assign w_f1        = (r_ir[15:12] >= 4'd4);
  assign w_legal     = w_jmp_fmt | w_f1 | w_f2;
  assign w_src       = w_f1 ? r_ir[11:8] : r_ir[3:0];
  assign w_as        = r_ir[5:4];
  assign w_ad        = w_f1 & r_ir[7];
  // R3 always, or R2 with As>=2, produces a constant without a memory read.
  assign w_cg        = (w_src == 4'd3) || ((w_src == 4'd2) && (w_as >= 2'd2));
  assign w_writes    = !((r_ir[15:12] == 4'h9) || (r_ir[15:12] == 4'hB));
  assign w_is_mov    = (r_ir[15:12] == 4'h4);
  // Format II operates in place, so a memory source is also the destination.
  assign w_mem_dst   = w_f1 ? w_ad : ((w_as != 2'd0) && !w_cg);
  // PC and SP always step by 2, even for byte operations.
  assign w_inc2      = ~r_ir[6] | (w_src <= 4'd1);
  assign w_dst_entry = (w_f1 && w_ad) ? DST_EXT : EXEC;

  logic       w_mem_req, w_pc_inc, w_srcx_ld, w_dstx_ld, w_sop_ld, w_dop_ld;
  logic       w_autoinc, w_inc2_o, w_rw, w_mw, w_jmp, w_done, w_illegal;
  logic [2:0] w_mab_sel;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Instruction register, loaded when the fetch completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_ir <= 16'h0000;
    else if (r_state == FETCH && bus.mem_rdy) r_ir <= bus.MDB_out;
  end

  // Next-state and strobe decode; strobes only fire on the completing cycle.
  always_comb begin
    w_next    = r_state;
    w_mem_req = 1'b0;
    w_mab_sel = 3'd0;
    w_pc_inc  = 1'b0;
    w_srcx_ld = 1'b0;
    w_dstx_ld = 1'b0;
    w_sop_ld  = 1'b0;
    w_dop_ld  = 1'b0;
    w_autoinc = 1'b0;
    w_inc2_o  = 1'b0;
    w_rw      = 1'b0;
    w_mw      = 1'b0;
    w_jmp     = 1'b0;
    w_done    = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      IDLE: w_next = FETCH;
      FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_rdy) begin
          w_pc_inc = 1'b1;
          w_next   = DECODE;
        end
      end
      DECODE: begin
        if (!w_legal) begin
          w_illegal = 1'b1;
          w_done    = 1'b1;
          w_next    = FETCH;
        end else if (w_jmp_fmt) begin
          w_next = EXEC;
        end else if (w_as == 2'd0 || w_cg) begin
          w_next = w_dst_entry;
        end else if (w_as == 2'd1 || (w_as == 2'd3 && w_src == 4'd0)) begin
          w_next = SRC_EXT;
        end else begin
          w_next = SRC_RD;
        end
      end
      SRC_EXT: begin
        w_mem_req = 1'b1;
        if (bus.mem_rdy) begin
          w_pc_inc = 1'b1;
          if (w_as == 2'd3) begin
            // Immediate: the extension word is the operand itself.
            w_sop_ld = 1'b1;
            w_next   = w_dst_entry;
          end else begin
            w_srcx_ld = 1'b1;
            w_next    = SRC_RD;
          end
        end
      end
      SRC_RD: begin
        w_mem_req = 1'b1;
        w_mab_sel = (w_as == 2'd1) ? 3'd2 : 3'd1;
        if (bus.mem_rdy) begin
          w_sop_ld  = 1'b1;
          w_autoinc = (w_as == 2'd3);
          w_inc2_o  = (w_as == 2'd3) & w_inc2;
          w_next    = w_dst_entry;
        end
      end
      DST_EXT: begin
        w_mem_req = 1'b1;
        if (bus.mem_rdy) begin
          w_dstx_ld = 1'b1;
          w_pc_inc  = 1'b1;
          // MOV overwrites the destination, so its old value is not needed.
          w_next    = w_is_mov ? EXEC : DST_RD;
        end
      end
      DST_RD: begin
        w_mem_req = 1'b1;
        w_mab_sel = 3'd2;
        if (bus.mem_rdy) begin
          w_dop_ld = 1'b1;
          w_next   = EXEC;
        end
      end
      EXEC: begin
        if (w_jmp_fmt) begin
          w_jmp  = 1'b1;
          w_done = 1'b1;
          w_next = FETCH;
        end else if (w_mem_dst && w_writes) begin
          w_next = DST_WR;
        end else begin
          w_rw   = !w_mem_dst && w_writes;
          w_done = 1'b1;
          w_next = FETCH;
        end
      end
      DST_WR: begin
        w_mem_req = 1'b1;
        w_mab_sel = 3'd2;
        if (bus.mem_rdy) begin
          w_mw   = 1'b1;
          w_done = 1'b1;
          w_next = FETCH;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.IR_out     = r_ir;
  assign bus.state      = r_state;
  assign bus.MEM_req    = w_mem_req;
  assign bus.MAB_sel    = w_mab_sel;
  assign bus.PC_inc     = w_pc_inc;
  assign bus.SRCX_ld    = w_srcx_ld;
  assign bus.DSTX_ld    = w_dstx_ld;
  assign bus.SOP_ld     = w_sop_ld;
  assign bus.DOP_ld     = w_dop_ld;
  assign bus.AUTOINC    = w_autoinc;
  assign bus.INC2       = w_inc2_o;
  assign bus.RW         = w_rw;
  assign bus.MW         = w_mw;
  assign bus.JMP        = w_jmp;
  assign bus.instr_done = w_done;
  assign bus.illegal    = w_illegal;

endmodule

// File: doc/instr_seq.md
# instr_seq

Multi-cycle instruction sequencer for the MSP430 core. It owns the instruction register and steps each instruction through fetch, extension-word fetch, operand reads, execute and memory write-back. It drives the MAB source select, register-file/memory write strobes and operand-latch enables for the existing datapath. It sits between ROM/RAM (MAB/MDB, `mem_rdy` handshake) and the register file, function unit and CALC adder. It replaces ad-hoc MAB/PC comparison with an explicit FSM.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `MDB_out`  in  16  memory data bus (instruction, extension word or operand).
- `mem_rdy`  in  1  memory completes the current access this cycle.
- `IR_out`  out  16  registered instruction word.
- `state`  out  4  current FSM state (encoding below).
- `MEM_req`  out  1  bus access in progress.
- `MAB_sel`  out  3  MAB source: 0 PC, 1 Sout, 2 CALC.
- `PC_inc`  out  1  advance PC by 2.
- `SRCX_ld`, `DSTX_ld`  out  1 each  latch source/destination extension word from MDB.
- `SOP_ld`, `DOP_ld`  out  1 each  latch source/destination memory operand from MDB.
- `AUTOINC`  out  1  post-increment source register.
- `INC2`  out  1  increment amount: 1 means +2, 0 means +1.
- `RW`  out  1  register-file write strobe.
- `MW`  out  1  memory write strobe.
- `JMP`  out  1  evaluate jump condition / load PC offset.
- `instr_done`  out  1  last cycle of an instruction.
- `illegal`  out  1  unsupported opcode seen.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, SRC_EXT=3, SRC_RD=4, DST_EXT=5, DST_RD=6, EXEC=7, DST_WR=8.
- Bus states are FETCH, SRC_EXT, SRC_RD, DST_EXT, DST_RD and DST_WR.
  - `MEM_req`=1 throughout each bus state.
  - The FSM holds the state until `mem_rdy`=1 at posedge.
  - Strobes are asserted combinationally only in the cycle where `mem_rdy`=1.
- FETCH: MAB_sel=0; on `mem_rdy`: IR<=MDB_out, `PC_inc`=1, go to DECODE.
- Decode of IR:
  - Jump format when IR[15:13]=001.
  - Format II when IR[15:10]=000100 and IR[9:7]<=3 (RRC/SWPB/RRA/SXT).
  - Format I when IR[15:12]>=4.
  - Anything else (including PUSH/CALL/RETI): `illegal`=1 for one DECODE cycle, `instr_done`=1, go to FETCH.
- Field extraction:
  - Source register S = IR[11:8] (format I) or IR[3:0] (format II).
  - As = IR[5:4]; Ad = IR[7] (format I only; 0 for format II).
- Constant generator: S=3, or S=2 with As>=2. These need no source memory cycles.
- Source path from DECODE:
  - As=00 or CG: go straight to the destination path.
  - As=01 (indexed, or absolute when S=2): SRC_EXT (MAB_sel=0, `SRCX_ld`, `PC_inc`), then SRC_RD (MAB_sel=2, `SOP_ld`).
  - As=10: SRC_RD (MAB_sel=1, `SOP_ld`).
  - As=11 with S=0 (immediate): SRC_EXT only, asserting `SOP_ld` and `PC_inc`.
  - As=11 otherwise: SRC_RD (MAB_sel=1, `SOP_ld`, `AUTOINC`).
  - `INC2` = ~IR[6] | (S<=1).
- Destination path:
  - Format I with Ad=1: DST_EXT (`DSTX_ld`, `PC_inc`), then DST_RD (MAB_sel=2, `DOP_ld`). DST_RD is skipped for MOV (IR[15:12]=4).
  - Then EXEC.
- EXEC, one cycle:
  - Writing ops are all except CMP (9) and BIT (B).
  - Register destination (format I Ad=0, or format II As=00): `RW`=1 for writing ops, `instr_done`=1, go to FETCH.
  - Memory destination with a writing op: go to DST_WR. This covers format I Ad=1, and format II with As in {01,10,11} and not CG.
  - Non-writing op: `instr_done`=1, go to FETCH.
  - Jump format: DECODE goes directly to EXEC, which asserts `JMP`=1 and `instr_done`=1.
- DST_WR: MAB_sel=2; on `mem_rdy`: `MW`=1, `instr_done`=1, go to FETCH.
- IDLE: entered only from reset; always goes to FETCH on the next posedge.

## Timing
- Reset: state=IDLE and IR_out=0. All outputs are 0, including MAB_sel=0.
- Reset mid-instruction aborts immediately. No `MW` or `RW` is issued for the aborted instruction.
- Cycle counts with `mem_rdy` held at 1 (FETCH through the `instr_done` cycle):
  - register-register: 3
  - jump: 3
  - @Rn source: 4
  - #imm source: 4
  - x(Rn)→Rm: 5
  - Rn→x(Rm) non-MOV: 6
  - Rn→x(Rm) MOV: 5
  - x(Rn)→x(Rm): 8
- Each `mem_rdy`=0 cycle in a bus state adds exactly one cycle. All outputs of that state are held except the completion strobes.
- Every strobe is asserted for exactly one cycle per transition.
- `PC_inc` fires exactly once per instruction word consumed.
- `AUTOINC` and `SOP_ld` coincide in the same cycle.

## Test plan
- Reset during SRC_RD with `mem_rdy`=0 -> state=0 and IR_out=0 immediately; no `MW`/`RW`; FETCH on the first posedge after `rst` falls.
- `mem_rdy`=1, MDB=0x4405 (MOV R4,R5) -> states 1,2,7; `RW`=1 in cycle 3; `PC_inc`=1 only in cycle 1.
- MDB sequence 0x4035, 0x1234 (MOV #0x1234,R5) -> states 1,2,3,7; `SOP_ld` and `PC_inc` in SRC_EXT; `RW`=1 in EXEC.
- 0x5495 (ADD x(R4),y(R5)) with `mem_rdy` low for 2 cycles in DST_RD -> states 1,2,3,4,5,6,6,6,7,8; `MW`=1 once; `instr_done` in DST_WR.
- 0x4435 (MOV.W @R4+,R5) then 0x4475 (MOV.B) -> `AUTOINC`=1 with `INC2`=1, then `INC2`=0.
- 0x2400 (JEQ) -> `JMP`=1 in cycle 3, `RW`=`MW`=0. 0x0000 -> `illegal`=1 in DECODE, then FETCH.
